cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, writeback value width.
REQ-002 Parameters SHALL be: IDX_W, default 5, ROB index width.
REQ-003 Parameters SHALL be: QDEPTH, default 2, per-unit queue depth (power of two, >=2).
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous and active-high.
REQ-006 {alu,mul,lsu}_valid_i  input  1  each: writeback offered by that functional unit.
REQ-007 {alu,mul,lsu}_value_i  input  DATA_W  each: writeback result.
REQ-008 {alu,mul,lsu}_rob_idx_i  input  IDX_W  each: destination ROB entry.
REQ-009 {alu,mul,lsu}_ready_o  output  1  each: unit queue can accept this cycle.
REQ-010 cdb_valid_o  output  1  broadcast slot holds a result.
REQ-011 cdb_value_o  output  DATA_W  broadcast result.
REQ-012 cdb_rob_idx_o  output  IDX_W  broadcast ROB index.
REQ-013 cdb_src_o  output  2  source of the broadcast: 0=ALU, 1=MUL, 2=LSU.
REQ-014 cdb_ready_i  input  1  ROB/consumer accepts the broadcast this cycle.

Function
REQ-015 Each unit SHALL own one FIFO of QDEPTH entries {value, rob_idx}, with a wrapping head pointer, tail pointer and count.
REQ-016 x_ready_o SHALL equal (count_x < QDEPTH), computed from registered count only.
REQ-017 A push SHALL occur when x_valid_i && x_ready_o; x_valid_i while not ready SHALL be dropped, and the unit SHALL hold it.
REQ-018 A full queue SHALL NOT accept a push in the same cycle it is popped; it accepts from the next cycle.
REQ-019 A push and a pop on a non-full queue in the same cycle SHALL leave count unchanged, and SHALL preserve FIFO order.
REQ-020 A pushed entry SHALL become eligible for grant the cycle after the push; there is no bypass.
REQ-021 The output slot SHALL be loadable when !cdb_valid_o || cdb_ready_i.
REQ-022 When the slot is loadable, the arbiter SHALL grant one non-empty queue, pop its head, and register it into cdb_* with cdb_src_o.
REQ-023 While cdb_valid_o && !cdb_ready_i, cdb_* SHALL hold stable, and no queue SHALL pop.
REQ-024 When the slot is loadable and all queues are empty, cdb_valid_o SHALL go 0 next cycle.
REQ-025 Minimum latency SHALL be 2 cycles: accepted at edge N, entry visible after N+1, cdb_valid_o high after N+2.
REQ-026 Sustained throughput SHALL be one broadcast per cycle while cdb_ready_i=1 and any queue is non-empty.
REQ-027 Exactly one grant SHALL occur per load; the other queues SHALL be unaffected.
REQ-028 Pointers SHALL wrap modulo QDEPTH, and count SHALL never exceed QDEPTH or underflow.

Reset
REQ-029 Reset SHALL clear all queue pointers and counts to 0.
REQ-030 Reset SHALL set cdb_valid_o=0, cdb_value_o=0, cdb_rob_idx_o=0, cdb_src_o=0 and the RR pointer=2, so ALU is searched first.
REQ-031 x_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all queued and broadcast entries, overriding any push or pop that cycle.

Configuration
REQ-033 Macro CDB_ARB_RR_EN defined SHALL select round-robin: the search starts at (last_grant+1) mod 3 in order ALU, MUL, LSU.
REQ-034 last_grant SHALL update only on a grant.
REQ-035 CDB_ARB_RR_EN undefined SHALL select fixed priority LSU > MUL > ALU; the RR pointer is absent.
REQ-036 All other behaviour SHALL be identical in both builds.

Verification
REQ-037 Single push: alu value 0x0000_0005, idx 3, at cycle 0, cdb_ready_i=1 -> cycle 2: cdb_valid_o=1, value 5, idx 3, src 0; cycle 3: cdb_valid_o=0.
REQ-038 Simultaneous: all three push at cycle 0 (idx 1/2/3), ready=1 -> RR build: ALU, MUL, LSU on cycles 2, 3, 4; fixed build: LSU, MUL, ALU.
REQ-039 Backpressure: cdb_ready_i=0 with 3 MUL pushes -> the output holds the first entry, the queue fills, and mul_ready_o=0 after 2 accepted plus 1 in the slot.
REQ-040 Backpressure release: with the queue full, raise cdb_ready_i -> entries drain in order, one per cycle.
REQ-041 Wrap: 10 back-to-back LSU pushes with ready=1 -> 10 broadcasts, idx order preserved, no drops, lsu_ready_o never 0.
REQ-042 Reset mid-stream: assert reset_i with 2 queued entries and cdb_valid_o=1 -> next cycle cdb_valid_o=0, all ready_o=1, and no stale entry emerges afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus writeback arbiter. The ALU, MUL and LSU each
//               own a small FIFO. One queue head per cycle is granted into a
//               registered broadcast slot, and the slot honours
//               valid/ready backpressure from the consumer.
//               Build option: define CDB_ARB_RR_EN to select round-robin
//               arbitration. The search starts after the last grant, in the
//               order ALU, MUL, LSU. Without the macro, fixed priority is used
//               (LSU > MUL > ALU).
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              alu_valid_i,
    input  logic [DATA_W-1:0] alu_value_i,
    input  logic [IDX_W-1:0]  alu_rob_idx_i,
    output logic              alu_ready_o,

    input  logic              mul_valid_i,
    input  logic [DATA_W-1:0] mul_value_i,
    input  logic [IDX_W-1:0]  mul_rob_idx_i,
    output logic              mul_ready_o,

    input  logic              lsu_valid_i,
    input  logic [DATA_W-1:0] lsu_value_i,
    input  logic [IDX_W-1:0]  lsu_rob_idx_i,
    output logic              lsu_ready_o,

    output logic              cdb_valid_o,
    output logic [DATA_W-1:0] cdb_value_o,
    output logic [IDX_W-1:0]  cdb_rob_idx_o,
    output logic [1:0]        cdb_src_o,
    input  logic              cdb_ready_i
);

    localparam int C_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int C_CNT_W = $clog2(QDEPTH) + 1;

    localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(QDEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

    // Source encodings double as unit indices into the per-unit arrays
    localparam logic [1:0] C_SRC_ALU = 2'd0;
    localparam logic [1:0] C_SRC_MUL = 2'd1;
    localparam logic [1:0] C_SRC_LSU = 2'd2;

    logic [2:0]        w_in_valid;
    logic [DATA_W-1:0] w_in_value   [3];
    logic [IDX_W-1:0]  w_in_idx     [3];
    logic [2:0]        w_ready;
    logic [2:0]        w_nonempty;
    logic [2:0]        w_push;
    logic [2:0]        w_grant;
    logic [DATA_W-1:0] w_head_value [3];
    logic [IDX_W-1:0]  w_head_idx   [3];

    logic              w_load;
    logic              w_any;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] w_sel_value;
    logic [IDX_W-1:0]  w_sel_idx;

    logic              r_cdb_valid;
    logic [DATA_W-1:0] r_cdb_value;
    logic [IDX_W-1:0]  r_cdb_idx;
    logic [1:0]        r_cdb_src;

    assign w_in_valid    = {lsu_valid_i, mul_valid_i, alu_valid_i};
    assign w_in_value[0] = alu_value_i;
    assign w_in_value[1] = mul_value_i;
    assign w_in_value[2] = lsu_value_i;
    assign w_in_idx[0]   = alu_rob_idx_i;
    assign w_in_idx[1]   = mul_rob_idx_i;
    assign w_in_idx[2]   = lsu_rob_idx_i;

    // Per-unit FIFO. Ready comes only from the registered count, so a full
    // queue that pops this cycle still refuses the push until the next cycle.
    for (genvar u = 0; u < 3; u++) begin : g_unit
        logic [DATA_W-1:0]  r_mem_value [QDEPTH];
        logic [IDX_W-1:0]   r_mem_idx   [QDEPTH];
        logic [C_PTR_W-1:0] r_head;
        logic [C_PTR_W-1:0] r_tail;
        logic [C_CNT_W-1:0] r_count;

        assign w_ready[u]      = (r_count < C_FULL);
        assign w_nonempty[u]   = (r_count != '0);
        assign w_push[u]       = w_in_valid[u] & w_ready[u];
        assign w_head_value[u] = r_mem_value[r_head];
        assign w_head_idx[u]   = r_mem_idx[r_head];

        // Storage write at the tail. Data needs no reset because count gates visibility.
        always_ff @(posedge clk_i) begin
            if (w_push[u]) begin
                r_mem_value[r_tail] <= w_in_value[u];
                r_mem_idx[r_tail]   <= w_in_idx[u];
            end
        end

        // Pointer and count bookkeeping. Pointers wrap because the depth is a power of two.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[u]) begin
                    r_tail <= r_tail + C_PTR_ONE;
                end
                if (w_grant[u]) begin
                    r_head <= r_head + C_PTR_ONE;
                end
                case ({w_push[u], w_grant[u]})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_load = !r_cdb_valid || cdb_ready_i;
    assign w_any  = |w_nonempty;

`ifdef CDB_ARB_RR_EN
    logic [1:0] r_last;

    // Round-robin choice: begin searching one past the most recent grant
    always_comb begin
        w_sel = C_SRC_ALU;
        case (r_last)
            C_SRC_ALU: begin
                if (w_nonempty[1])      w_sel = C_SRC_MUL;
                else if (w_nonempty[2]) w_sel = C_SRC_LSU;
                else                    w_sel = C_SRC_ALU;
            end
            C_SRC_MUL: begin
                if (w_nonempty[2])      w_sel = C_SRC_LSU;
                else if (w_nonempty[0]) w_sel = C_SRC_ALU;
                else                    w_sel = C_SRC_MUL;
            end
            default: begin
                if (w_nonempty[0])      w_sel = C_SRC_ALU;
                else if (w_nonempty[1]) w_sel = C_SRC_MUL;
                else                    w_sel = C_SRC_LSU;
            end
        endcase
    end

    // Remember the winner only when a grant actually happens
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last <= C_SRC_LSU;
        end else if (|w_grant) begin
            r_last <= w_sel;
        end
    end
`else
    // Fixed priority: LSU first, then MUL, then ALU
    always_comb begin
        w_sel = C_SRC_ALU;
        if (w_nonempty[2])      w_sel = C_SRC_LSU;
        else if (w_nonempty[1]) w_sel = C_SRC_MUL;
        else                    w_sel = C_SRC_ALU;
    end
`endif

    // One-hot pop for the selected queue, and only when the slot can load
    assign w_grant = (w_load && w_any) ? (3'b001 << w_sel) : 3'b000;

    // Head of the selected queue, presented to the broadcast register
    always_comb begin
        w_sel_value = w_head_value[0];
        w_sel_idx   = w_head_idx[0];
        case (w_sel)
            C_SRC_MUL: begin
                w_sel_value = w_head_value[1];
                w_sel_idx   = w_head_idx[1];
            end
            C_SRC_LSU: begin
                w_sel_value = w_head_value[2];
                w_sel_idx   = w_head_idx[2];
            end
            default: begin
                w_sel_value = w_head_value[0];
                w_sel_idx   = w_head_idx[0];
            end
        endcase
    end

    // Broadcast slot: loads when empty or consumed, and holds under backpressure
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cdb_valid <= 1'b0;
            r_cdb_value <= '0;
            r_cdb_idx   <= '0;
            r_cdb_src   <= C_SRC_ALU;
        end else if (w_load) begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_value <= w_sel_value;
                r_cdb_idx   <= w_sel_idx;
                r_cdb_src   <= w_sel;
            end
        end
    end

    assign alu_ready_o   = w_ready[0];
    assign mul_ready_o   = w_ready[1];
    assign lsu_ready_o   = w_ready[2];
    assign cdb_valid_o   = r_cdb_valid;
    assign cdb_value_o   = r_cdb_value;
    assign cdb_rob_idx_o = r_cdb_idx;
    assign cdb_src_o     = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter (default
//               parameters). Expected values are written by hand. The
//               arbitration order depends on whether CDB_ARB_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk;
    logic        reset_i;
    logic        alu_valid_i, mul_valid_i, lsu_valid_i;
    logic [31:0] alu_value_i, mul_value_i, lsu_value_i;
    logic [4:0]  alu_rob_idx_i, mul_rob_idx_i, lsu_rob_idx_i;
    logic        alu_ready_o, mul_ready_o, lsu_ready_o;
    logic        cdb_valid_o;
    logic [31:0] cdb_value_o;
    logic [4:0]  cdb_rob_idx_o;
    logic [1:0]  cdb_src_o;
    logic        cdb_ready_i;

    int n_checks;
    int n_errors;

    cdb_arbiter #(.DATA_W(32), .IDX_W(5), .QDEPTH(2)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .alu_valid_i   (alu_valid_i),
        .alu_value_i   (alu_value_i),
        .alu_rob_idx_i (alu_rob_idx_i),
        .alu_ready_o   (alu_ready_o),
        .mul_valid_i   (mul_valid_i),
        .mul_value_i   (mul_value_i),
        .mul_rob_idx_i (mul_rob_idx_i),
        .mul_ready_o   (mul_ready_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_value_i   (lsu_value_i),
        .lsu_rob_idx_i (lsu_rob_idx_i),
        .lsu_ready_o   (lsu_ready_o),
        .cdb_valid_o   (cdb_valid_o),
        .cdb_value_o   (cdb_value_o),
        .cdb_rob_idx_o (cdb_rob_idx_o),
        .cdb_src_o     (cdb_src_o),
        .cdb_ready_i   (cdb_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0; mul_valid_i = 1'b0; lsu_valid_i = 1'b0;
        alu_value_i = '0;   mul_value_i = '0;   lsu_value_i = '0;
        alu_rob_idx_i = '0; mul_rob_idx_i = '0; lsu_rob_idx_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        cdb_ready_i = 1'b1;
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cdb_ready_i = 1'b1;
        reset_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (cdb_valid_o !== 1'b0 || cdb_value_o !== 32'd0 || cdb_rob_idx_o !== 5'd0 || cdb_src_o !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b value=%h idx=%0d src=%0d, expected 0 0 0 0",
                     cdb_valid_o, cdb_value_o, cdb_rob_idx_o, cdb_src_o);
        end
        reset_i = 1'b0;
        tick();
        n_checks++;
        if ({alu_ready_o, mul_ready_o, lsu_ready_o} !== 3'b111 || cdb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: ready(alu,mul,lsu)=%b%b%b valid=%b, expected 111 valid 0",
                     alu_ready_o, mul_ready_o, lsu_ready_o, cdb_valid_o);
        end
    endtask

    task automatic test_single_push();
        do_reset();
        alu_valid_i = 1'b1; alu_value_i = 32'h0000_0005; alu_rob_idx_i = 5'd3;
        tick();
        alu_valid_i = 1'b0;
        n_checks++;
        if (cdb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c1_latency: valid=%b, expected 0", cdb_valid_o);
        end
        tick();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_value_o !== 32'd5 || cdb_rob_idx_o !== 5'd3 || cdb_src_o !== 2'd0) begin
            n_errors++;
            $display("FAIL single_c2: valid=%b value=%h idx=%0d src=%0d, expected 1 5 3 0",
                     cdb_valid_o, cdb_value_o, cdb_rob_idx_o, cdb_src_o);
        end
        tick();
        n_checks++;
        if (cdb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_c3_empty: valid=%b, expected 0", cdb_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0]  exp_src [3];
        logic [4:0]  exp_idx [3];
        logic [31:0] exp_val [3];
`ifdef CDB_ARB_RR_EN
        exp_src[0] = 2'd0; exp_idx[0] = 5'd1; exp_val[0] = 32'h11;
        exp_src[1] = 2'd1; exp_idx[1] = 5'd2; exp_val[1] = 32'h22;
        exp_src[2] = 2'd2; exp_idx[2] = 5'd3; exp_val[2] = 32'h33;
`else
        exp_src[0] = 2'd2; exp_idx[0] = 5'd3; exp_val[0] = 32'h33;
        exp_src[1] = 2'd1; exp_idx[1] = 5'd2; exp_val[1] = 32'h22;
        exp_src[2] = 2'd0; exp_idx[2] = 5'd1; exp_val[2] = 32'h11;
`endif
        do_reset();
        alu_valid_i = 1'b1; alu_value_i = 32'h11; alu_rob_idx_i = 5'd1;
        mul_valid_i = 1'b1; mul_value_i = 32'h22; mul_rob_idx_i = 5'd2;
        lsu_valid_i = 1'b1; lsu_value_i = 32'h33; lsu_rob_idx_i = 5'd3;
        tick();
        idle_inputs();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (cdb_valid_o !== 1'b1 || cdb_src_o !== exp_src[k] || cdb_rob_idx_o !== exp_idx[k] ||
                cdb_value_o !== exp_val[k]) begin
                n_errors++;
                $display("FAIL simultaneous_slot%0d: valid=%b src=%0d idx=%0d value=%h, expected 1 %0d %0d %h",
                         k, cdb_valid_o, cdb_src_o, cdb_rob_idx_o, cdb_value_o, exp_src[k], exp_idx[k], exp_val[k]);
            end
            tick();
        end
        n_checks++;
        if (cdb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL simultaneous_drained: valid=%b, expected 0", cdb_valid_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cdb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mul_valid_i = 1'b1; mul_value_i = 32'h40 + 32'(k); mul_rob_idx_i = 5'(4 + k);
            n_checks++;
            if (mul_ready_o !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_ready_push%0d: mul_ready=%b, expected 1", k, mul_ready_o);
            end
            tick();
        end
        // Keep offering an entry that must be dropped while the queue is full.
        mul_value_i = 32'h77; mul_rob_idx_i = 5'd7;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mul_ready_o !== 1'b0 || cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 5'd4 ||
                cdb_value_o !== 32'h40 || cdb_src_o !== 2'd1) begin
                n_errors++;
                $display("FAIL bp_hold%0d: mul_ready=%b valid=%b idx=%0d value=%h src=%0d, expected 0 1 4 40 1",
                         k, mul_ready_o, cdb_valid_o, cdb_rob_idx_o, cdb_value_o, cdb_src_o);
            end
            tick();
        end
        mul_valid_i = 1'b0;
        cdb_ready_i = 1'b1;
        n_checks++;
        if (cdb_rob_idx_o !== 5'd4 || mul_ready_o !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release_edge: idx=%0d mul_ready=%b, expected 4 0", cdb_rob_idx_o, mul_ready_o);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 5'(5 + k) || cdb_value_o !== 32'h41 + 32'(k)) begin
                n_errors++;
                $display("FAIL bp_drain%0d: valid=%b idx=%0d value=%h, expected 1 %0d %h",
                         k, cdb_valid_o, cdb_rob_idx_o, cdb_value_o, 5 + k, 32'h41 + 32'(k));
            end
            tick();
        end
        n_checks++;
        if (cdb_valid_o !== 1'b0 || mul_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_drained: valid=%b mul_ready=%b, expected 0 1", cdb_valid_o, mul_ready_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                lsu_valid_i = 1'b1; lsu_value_i = 32'h100 + 32'(c); lsu_rob_idx_i = 5'(c + 1);
                n_checks++;
                if (lsu_ready_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL wrap_ready_c%0d: lsu_ready=%b, expected 1", c, lsu_ready_o);
                end
            end else begin
                lsu_valid_i = 1'b0;
            end
            if (c >= 2) begin
                n_checks++;
                if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 5'(c - 1) || cdb_value_o !== 32'h100 + 32'(c - 2) ||
                    cdb_src_o !== 2'd2) begin
                    n_errors++;
                    $display("FAIL wrap_out_c%0d: valid=%b idx=%0d value=%h src=%0d, expected 1 %0d %h 2",
                             c, cdb_valid_o, cdb_rob_idx_o, cdb_value_o, cdb_src_o, c - 1, 32'h100 + 32'(c - 2));
                end
            end
            tick();
        end
        n_checks++;
        if (cdb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_end: valid=%b, expected 0", cdb_valid_o);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cdb_ready_i = 1'b0;
        alu_valid_i = 1'b1; alu_value_i = 32'h90; alu_rob_idx_i = 5'd9;
        mul_valid_i = 1'b1; mul_value_i = 32'hA0; mul_rob_idx_i = 5'd10;
        tick();
        alu_valid_i = 1'b0; mul_valid_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_value_i = 32'hB0; lsu_rob_idx_i = 5'd11;
        tick();
        lsu_valid_i = 1'b0;
        n_checks++;
        if (cdb_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_pre: valid=%b, expected 1", cdb_valid_o);
        end
        // Reset must also override a push offered in the same cycle.
        reset_i = 1'b1;
        alu_valid_i = 1'b1; alu_value_i = 32'hC0; alu_rob_idx_i = 5'd12;
        tick();
        reset_i = 1'b0;
        alu_valid_i = 1'b0;
        cdb_ready_i = 1'b1;
        n_checks++;
        if (cdb_valid_o !== 1'b0 || {alu_ready_o, mul_ready_o, lsu_ready_o} !== 3'b111) begin
            n_errors++;
            $display("FAIL midreset_after: valid=%b ready=%b%b%b, expected 0 111",
                     cdb_valid_o, alu_ready_o, mul_ready_o, lsu_ready_o);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (cdb_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_stale%0d: valid=%b idx=%0d, expected valid 0", k, cdb_valid_o, cdb_rob_idx_o);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_i = 1'b1;
        cdb_ready_i = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_simultaneous();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
